// File: rtl/arriskv_pkg.sv
// Shared RV32I decode types: operations, instruction formats and major opcodes.
package arriskv_pkg;

  typedef enum logic [5:0] {
    OP_NOP,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} instr_fmt_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic fmt_uses_rs1(instr_fmt_t fmt);
    return !(fmt inside {FMT_U, FMT_J});
  endfunction

  function automatic logic fmt_uses_rs2(instr_fmt_t fmt);
    return fmt inside {FMT_R, FMT_S, FMT_B};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for each RV32I instruction format.
module imm_gen
  import arriskv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]      instr_i,
  input  instr_fmt_t       fmt_i,
  output logic [XLEN-1:0]  imm_o
);

  logic signed [31:0] imm32;
  logic               unused_opc;

  assign unused_opc = ^instr_i[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt_i)
      FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      FMT_U:   imm32 = {instr_i[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed source, so the size cast sign-extends for XLEN=64.
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: valid/ready on both sides, load-use stall, flush, illegal flagging.
module decode_stage
  import arriskv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned N_REGS    = 32,
  parameter bit          HAZARD_EN = 1'b1,
  localparam int unsigned AW       = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [2*AW-1:0]   reg_rd_addr,
  input  logic [2*XLEN-1:0] reg_rd_data,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [AW-1:0]     ex_rdest,
  output logic              out_valid,
  input  logic              out_ready,
  output op_t               out_op,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [AW-1:0]     out_rdest,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_jump,
  output logic              out_illegal
);

  logic [6:0]    opc, f7;
  logic [2:0]    f3;
  logic [AW-1:0] rs1, rs2, rd;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  assign rd  = in_instr[7 +: AW];
  assign rs1 = in_instr[15 +: AW];
  assign rs2 = in_instr[20 +: AW];

  assign reg_rd_addr = {rs2, rs1};

  op_t             dec_op;
  instr_fmt_t      dec_fmt;
  logic            dec_illegal, dec_bad_opc, dec_writes_rd, dec_jump;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_op        = OP_NOP;
    dec_fmt       = FMT_R;
    dec_illegal   = 1'b0;
    dec_bad_opc   = 1'b0;
    dec_writes_rd = 1'b0;
    dec_jump      = 1'b0;
    case (opc)
      OPC_LOAD: begin
        dec_fmt       = FMT_I;
        dec_writes_rd = 1'b1;
        case (f3)
          3'b000:  dec_op = OP_LB;
          3'b001:  dec_op = OP_LH;
          3'b010:  dec_op = OP_LW;
          3'b100:  dec_op = OP_LBU;
          3'b101:  dec_op = OP_LHU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        case (f3)
          3'b000:  dec_op = OP_SB;
          3'b001:  dec_op = OP_SH;
          3'b010:  dec_op = OP_SW;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec_fmt       = FMT_R;
        dec_writes_rd = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          dec_op = OP_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_fmt       = FMT_I;
        dec_writes_rd = 1'b1;
        case (f3)
          3'b000: dec_op = OP_ADDI;
          3'b010: dec_op = OP_SLTI;
          3'b011: dec_op = OP_SLTIU;
          3'b100: dec_op = OP_XORI;
          3'b110: dec_op = OP_ORI;
          3'b111: dec_op = OP_ANDI;
          3'b001: begin
            if (f7 == F7_BASE) dec_op = OP_SLLI;
            else               dec_illegal = 1'b1;
          end
          default: begin
            if (f7 == F7_BASE)     dec_op = OP_SRLI;
            else if (f7 == F7_ALT) dec_op = OP_SRAI;
            else                   dec_illegal = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        dec_fmt       = FMT_U;
        dec_writes_rd = 1'b1;
        dec_op        = OP_LUI;
      end
      OPC_AUIPC: begin
        dec_fmt       = FMT_U;
        dec_writes_rd = 1'b1;
        dec_op        = OP_AUIPC;
      end
      OPC_BRANCH: begin
        dec_fmt  = FMT_B;
        dec_jump = 1'b1;
        case (f3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_fmt       = FMT_J;
        dec_writes_rd = 1'b1;
        dec_jump      = 1'b1;
        dec_op        = OP_JAL;
      end
      OPC_JALR: begin
        dec_fmt       = FMT_I;
        dec_writes_rd = 1'b1;
        dec_jump      = 1'b1;
        if (f3 == 3'b000) dec_op = OP_JALR;
        else              dec_illegal = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
        dec_bad_opc = 1'b1;
      end
    endcase
    // An illegal instruction travels as a bare NOP with no side effects.
    if (dec_illegal) begin
      dec_op        = OP_NOP;
      dec_writes_rd = 1'b0;
      dec_jump      = 1'b0;
    end
  end

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr_i (in_instr),
    .fmt_i   (dec_fmt),
    .imm_o   (dec_imm)
  );

  logic uses_rs1, uses_rs2, stall, accept;

  assign uses_rs1 = !dec_bad_opc && fmt_uses_rs1(dec_fmt);
  assign uses_rs2 = !dec_bad_opc && fmt_uses_rs2(dec_fmt);

  assign stall = HAZARD_EN && ex_valid && ex_is_load && (ex_rdest != '0) &&
                 ((uses_rs1 && rs1 == ex_rdest) || (uses_rs2 && rs2 == ex_rdest));

  // Holding in_ready low in reset keeps fetch from believing an instruction was taken.
  assign in_ready = rst_n && (!out_valid || out_ready) && !stall && !flush;
  assign accept   = in_valid && in_ready;

  logic            valid_d, jump_d, illegal_d;
  op_t             op_d;
  logic [XLEN-1:0] imm_d, rs1_data_d, rs2_data_d, pc_d;
  logic [AW-1:0]   rdest_d;

  always_comb begin
    valid_d    = out_valid;
    op_d       = out_op;
    imm_d      = out_imm;
    rs1_data_d = out_rs1_data;
    rs2_data_d = out_rs2_data;
    rdest_d    = out_rdest;
    pc_d       = out_pc;
    jump_d     = out_jump;
    illegal_d  = out_illegal;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      op_d       = dec_op;
      imm_d      = dec_illegal ? '0 : dec_imm;
      rs1_data_d = reg_rd_data[XLEN-1:0];
      rs2_data_d = reg_rd_data[2*XLEN-1:XLEN];
      rdest_d    = dec_writes_rd ? rd : '0;
      pc_d       = in_pc;
      jump_d     = dec_jump;
      illegal_d  = dec_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_op       <= OP_NOP;
      out_imm      <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rdest    <= '0;
      out_pc       <= '0;
      out_jump     <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      out_valid    <= valid_d;
      out_op       <= op_d;
      out_imm      <= imm_d;
      out_rs1_data <= rs1_data_d;
      out_rs2_data <= rs2_data_d;
      out_rdest    <= rdest_d;
      out_pc       <= pc_d;
      out_jump     <= jump_d;
      out_illegal  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed vector table plus handshake, hazard, flush and reset sequences for decode_stage.
module tb_decode_stage;
  import arriskv_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;
  logic [2*AW-1:0]   reg_rd_addr;
  logic [2*XLEN-1:0] reg_rd_data;
  logic              ex_valid, ex_is_load;
  logic [AW-1:0]     ex_rdest;
  logic              out_valid, out_ready, out_jump, out_illegal;
  op_t               out_op;
  logic [XLEN-1:0]   out_imm, out_rs1_data, out_rs2_data, out_pc;
  logic [AW-1:0]     out_rdest;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN      (XLEN),
    .N_REGS    (32),
    .HAZARD_EN (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .reg_rd_addr  (reg_rd_addr),
    .reg_rd_data  (reg_rd_data),
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_rdest     (ex_rdest),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_imm      (out_imm),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rdest    (out_rdest),
    .out_pc       (out_pc),
    .out_jump     (out_jump),
    .out_illegal  (out_illegal)
  );

  // Register file model: x0 reads zero, others a recognisable pattern.
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : 32'hA000_0000 + 32'({a, a});
  endfunction

  always_comb reg_rd_data = {rf(reg_rd_addr[2*AW-1:AW]), rf(reg_rd_addr[AW-1:0])};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    op_t         op;
    logic [31:0] imm;
    logic [4:0]  rdest;
    logic        jump;
    logic        illegal;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{32'hFFF00093, OP_ADDI,  32'hFFFFFFFF, 5'd1,  1'b0, 1'b0};
    vecs[1]  = '{32'hFE000EE3, OP_BEQ,   32'hFFFFFFFC, 5'd0,  1'b1, 1'b0};
    vecs[2]  = '{32'h00728333, OP_ADD,   32'h00000000, 5'd6,  1'b0, 1'b0};
    vecs[3]  = '{32'h402081B3, OP_SUB,   32'h00000000, 5'd3,  1'b0, 1'b0};
    vecs[4]  = '{32'h40325213, OP_SRAI,  32'h00000403, 5'd4,  1'b0, 1'b0};
    vecs[5]  = '{32'h00325213, OP_SRLI,  32'h00000003, 5'd4,  1'b0, 1'b0};
    vecs[6]  = '{32'h00512423, OP_SW,    32'h00000008, 5'd0,  1'b0, 1'b0};
    vecs[7]  = '{32'h12345537, OP_LUI,   32'h12345000, 5'd10, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFF097, OP_AUIPC, 32'hFFFFF000, 5'd1,  1'b0, 1'b0};
    vecs[9]  = '{32'h010000EF, OP_JAL,   32'h00000010, 5'd1,  1'b1, 1'b0};
    vecs[10] = '{32'h00008067, OP_JALR,  32'h00000000, 5'd0,  1'b1, 1'b0};
    vecs[11] = '{32'hFFC1A103, OP_LW,    32'hFFFFFFFC, 5'd2,  1'b0, 1'b0};
    vecs[12] = '{32'h003160B3, OP_OR,    32'h00000000, 5'd1,  1'b0, 1'b0};
    vecs[13] = '{32'h003170B3, OP_AND,   32'h00000000, 5'd1,  1'b0, 1'b0};
    vecs[14] = '{32'h0000007F, OP_NOP,   32'h00000000, 5'd0,  1'b0, 1'b1};
    vecs[15] = '{32'h02728333, OP_NOP,   32'h00000000, 5'd0,  1'b0, 1'b1};
    vecs[16] = '{32'hFFC1B103, OP_NOP,   32'h00000000, 5'd0,  1'b0, 1'b1};
    vecs[17] = '{32'hFE002EE3, OP_NOP,   32'h00000000, 5'd0,  1'b0, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = '0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rdest = '0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_op", 64'(out_op), 64'(OP_NOP));
    check("reset out_imm", 64'(out_imm), 64'd0);
    check("reset out_rdest", 64'(out_rdest), 64'd0);
    check("reset out_pc", 64'(out_pc), 64'd0);
    check("reset flags", 64'({out_jump, out_illegal}), 64'd0);

    // Table: one accept per cycle with both sides ready.
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(i) * 4;
      #1;
      check("tbl in_ready", 64'(in_ready), 64'd1);
      tick();
      check("tbl out_valid", 64'(out_valid), 64'd1);
      check("tbl out_op", 64'(out_op), 64'(vecs[i].op));
      check("tbl out_imm", 64'(out_imm), 64'(vecs[i].imm));
      check("tbl out_rdest", 64'(out_rdest), 64'(vecs[i].rdest));
      check("tbl out_jump", 64'(out_jump), 64'(vecs[i].jump));
      check("tbl out_illegal", 64'(out_illegal), 64'(vecs[i].illegal));
      check("tbl out_pc", 64'(out_pc), 64'(32'h1000 + 32'(i) * 4));
      check("tbl rs1_data", 64'(out_rs1_data), 64'(rf(vecs[i].instr[19:15])));
      check("tbl rs2_data", 64'(out_rs2_data), 64'(rf(vecs[i].instr[24:20])));
    end
    in_valid = 1'b0;
    tick();
    check("drain out_valid", 64'(out_valid), 64'd0);

    // Backpressure: ADDI held for 3 cycles while ADD waits upstream.
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h2000;
    tick();
    out_ready = 1'b0; in_instr = 32'h00728333; in_pc = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp in_ready", 64'(in_ready), 64'd0);
      tick();
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp out_op held", 64'(out_op), 64'(OP_ADDI));
      check("bp out_imm held", 64'(out_imm), 64'hFFFFFFFF);
      check("bp out_pc held", 64'(out_pc), 64'h2000);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp next op", 64'(out_op), 64'(OP_ADD));
    check("bp next pc", 64'(out_pc), 64'h2004);

    // Load-use on rs1: ADD x6,x5,x7 behind a load to x5.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rdest = 5'd5; in_pc = 32'h3000;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("lu rs1 in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    check("lu bubble out_valid", 64'(out_valid), 64'd0);
    ex_rdest = 5'd7;
    #1;
    check("lu rs2 in_ready", 64'(in_ready), 64'd0);
    ex_is_load = 1'b0;
    #1;
    check("lu non-load in_ready", 64'(in_ready), 64'd1);
    ex_is_load = 1'b1; ex_rdest = 5'd0;
    #1;
    check("lu x0 in_ready", 64'(in_ready), 64'd1);
    ex_rdest = 5'd5; in_instr = 32'h12345537; // LUI has no source registers
    #1;
    check("lu lui in_ready", 64'(in_ready), 64'd1);
    in_instr = 32'h00728333;
    #1;
    check("lu restall in_ready", 64'(in_ready), 64'd0);
    ex_valid = 1'b0;
    #1;
    check("lu drop in_ready", 64'(in_ready), 64'd1);
    tick();
    check("lu accept valid", 64'(out_valid), 64'd1);
    check("lu accept op", 64'(out_op), 64'(OP_ADD));
    check("lu accept pc", 64'(out_pc), 64'h3000);

    // Flush with a valid output and a new instruction offered.
    flush = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h4000;
    #1;
    check("flush in_ready", 64'(in_ready), 64'd0);
    tick();
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush no accept", 64'(out_pc), 64'h3000);
    // Flush overrides backpressure too.
    flush = 1'b0;
    tick();
    out_ready = 1'b0; flush = 1'b1;
    tick();
    check("flush held out_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; out_ready = 1'b1;

    // Reset while an output is pending and upstream is offering.
    tick();
    out_ready = 1'b0; in_instr = 32'h00512423;
    tick();
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset out_op", 64'(out_op), 64'(OP_NOP));
    check("mid reset out_pc", 64'(out_pc), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("post reset out_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
